mcpu_mem: RTL and testbench
===========================

# mcpu_mem

Memory responder and boot loader for the minimal 8-bit CPU bus. Holds a 64x8 RAM answering the CPU's address/data/strobe interface. Reads are combinational and writes are qualified by the CPU's clock-gated active-low write strobe. A byte-stream loader fills the RAM while holding the CPU in reset, then releases it.

## Interface
- `LOAD_LEN`, default 64: bytes per load, written to addresses 0..LOAD_LEN-1; legal range 1..64.
- `clk` input 1: clock, shared with the CPU.
- `rst` input 1: reset, synchronous, active-low. Clock is `clk`.
- `cpu_addr` input 6: CPU address, stable from posedge to the next posedge.
- `cpu_wdata` input 8: CPU write data, i.e. the accumulator.
- `cpu_we_n` input 1: active-low write strobe. It is clock-gated, so it is only ever low while `clk` is low.
- `cpu_oe_n` input 1: active-low output enable. It is unused internally; the port exists for bus completeness.
- `cpu_rdata` output 8: `mem[cpu_addr]`, combinational.
- `cpu_rst_n` output 1: registered; drives the CPU's active-low reset.
- `ld_start` input 1: single-cycle pulse that restarts a load.
- `ld_valid` input 1: loader source has a byte.
- `ld_data` input 8: loader byte.
- `ld_ready` output 1: loader accepts a byte.
- `ld_done` output 1: high in RUN.
- `ld_sum` output 8: mod-256 sum of the bytes accepted in the current load.

## Operation
- **States:**
  - LOAD: `cnt` runs 0..LOAD_LEN-1.
  - RELEASE: lasts 1 cycle.
  - RUN.
- **Reset:** `rst` low at a posedge sets state to LOAD and clears `cnt` and `ld_sum` to 0. It sets `cpu_rst_n` to 0. RAM contents are not cleared.
- **LOAD handshake:**
  - A handshake is `ld_valid & ld_ready` at a posedge.
  - Each handshake writes `mem[cnt] <= ld_data`, increments `cnt`, and adds `ld_data` to `ld_sum`.
  - A handshake with `cnt == LOAD_LEN-1` moves the state to RELEASE.
- **RELEASE:** next posedge goes to RUN and sets `cpu_rst_n` to 1.
- **`ld_start`:** in any state, `ld_start` high at a posedge goes to LOAD, clears `cnt` and `ld_sum`, and sets `cpu_rst_n` to 0. It beats a coincident handshake; that byte is discarded and not written.
- **CPU write qualification:**
  - Write qualifier `wr_q` is a latch transparent while `clk` is low: `wr_q = ~cpu_we_n`. It holds across the rising edge.
  - At a posedge with state RUN and `wr_q = 1`: `mem[cpu_addr] <= cpu_wdata`.
  - CPU writes are ignored in LOAD and RELEASE.
- **Read port:** `cpu_rdata = mem[cpu_addr]` at all times, independent of `cpu_oe_n`. The CPU samples read data at posedge, when `cpu_oe_n` is already high.
- **Write collision:** there is only one write source per state, so a loader write and a CPU write never coincide.
- **Outputs:**
  - `ld_ready = rst & (state == LOAD)`, combinational.
  - `ld_done = (state == RUN)`.
- **Arithmetic:** `cnt` is 7 bits and never exceeds LOAD_LEN-1 in LOAD. `ld_sum` wraps modulo 256.

## Timing
- **Reset values:** `cpu_rst_n` 0, `ld_ready` 0 while `rst` low, `ld_done` 0, `ld_sum` 0. `cpu_rdata` follows RAM and is undefined until written.
- **`ld_ready` timing:**
  - Goes high in the first cycle after the reset edge.
  - Drops in the cycle after the final handshake edge.
- **`cpu_rst_n` release:** rises at the second posedge after the final handshake, i.e. the RELEASE→RUN edge.
- **Loader write latency:** a byte written at edge N is visible on `cpu_rdata` right after edge N.
- **CPU write latency:** a write strobed in the low phase before edge N commits at edge N. The new value is readable after edge N.
- **`ld_start` latency:** `cpu_rst_n` falls at the same edge that samples `ld_start`.
- **Throughput:** the loader takes one byte per cycle with `ld_valid` held high. A full load takes LOAD_LEN cycles.
- **Reset mid-load:** the count restarts at 0. Bytes already written stay in the RAM.

## Configuration
- `MCPU_MEM_CHECKSUM_EN`:
  - Defined: `ld_sum` accumulates as described.
  - Undefined: no adder is built, `ld_sum` is constant 0x00, and all other behaviour is identical.

## Test plan
- **Full boot load:** release reset, stream 0x00..0x3F with `ld_valid` held high → 64 handshakes; `ld_ready` low from the 65th cycle; `cpu_rst_n` rises 2 edges after the last handshake; `cpu_addr` = 0x05 gives `cpu_rdata` = 0x05; `ld_sum` = 0xE0 (0x00 with the macro off).
- **Source gaps:** toggle `ld_valid` 1,0,0,1 over the first bytes → only valid cycles advance `cnt`; `mem[0]` and `mem[1]` hold the 1st and 4th presented values.
- **CPU write in RUN:** `cpu_addr` = 0x3E, `cpu_wdata` = 0xA5, `cpu_we_n` low during the clk-low phase → `cpu_rdata` = 0xA5 after that edge; `mem[0x3D]` unchanged.
- **`ld_start` during load:** assert `ld_start` coincident with the handshake at `cnt` = 10, `ld_data` = 0x77 → `mem[10]` not written; `cnt` = 0, `ld_sum` = 0; `cpu_rst_n` stays 0; the next byte lands at address 0.
- **Reset mid-load:** drop `rst` for one edge at `cnt` = 20 → state LOAD, `cnt` 0; `mem[0..19]` retained; `ld_ready` low while `rst` low.
- **CPU write blocked:** `cpu_we_n` low during LOAD to address 0x30 with data 0xFF → `mem[0x30]` unchanged.

Source files
------------

// File: rtl/mcpu_mem_if.sv
`default_nettype none
// ============================================================================
// mcpu_mem_if : CPU memory bus plus boot-loader byte stream for mcpu_mem
// Revision    : 1.0
// ============================================================================
interface mcpu_mem_if;
   logic [5:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       cpu_we_n;
   logic       cpu_oe_n;
   logic [7:0] cpu_rdata;
   logic       cpu_rst_n;
   logic       ld_start;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       ld_ready;
   logic       ld_done;
   logic [7:0] ld_sum;

   modport master (
      output cpu_addr, cpu_wdata, cpu_we_n, cpu_oe_n, ld_start, ld_valid, ld_data,
      input  cpu_rdata, cpu_rst_n, ld_ready, ld_done, ld_sum
   );

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_we_n, cpu_oe_n, ld_start, ld_valid, ld_data,
      output cpu_rdata, cpu_rst_n, ld_ready, ld_done, ld_sum
   );
endinterface
`default_nettype wire

// File: rtl/mcpu_mem.sv
`default_nettype none
// ============================================================================
// mcpu_mem : 64x8 RAM for the 8-bit CPU with a byte-stream boot loader that
//            holds the CPU in reset until LOAD_LEN bytes have been written.
//            Define MCPU_MEM_CHECKSUM_EN to build the ld_sum accumulator.
// Revision : 1.0
// ============================================================================
module mcpu_mem #(
   parameter int LOAD_LEN = 64
) (
   input  logic       clk,
   input  logic       rst,
   mcpu_mem_if.slave  bus
);
   localparam logic [1:0] c_st_load    = 2'd0;
   localparam logic [1:0] c_st_release = 2'd1;
   localparam logic [1:0] c_st_run     = 2'd2;
   localparam logic [6:0] c_last       = 7'(LOAD_LEN - 1);

   logic [1:0] state_q, state_d;
   logic [6:0] cnt_q, cnt_d;
   logic       cpu_rst_n_q, cpu_rst_n_d;
   logic       wr_q;
   logic       ld_ready_w;
   logic       hs_w;
   logic       mem_we_w;
   logic [5:0] mem_waddr_w;
   logic [7:0] mem_wdata_w;
   logic [7:0] mem [0:63];
   logic       unused_oe;

   assign unused_oe = bus.cpu_oe_n;

   // Strobe is only low while clk is low; the latch carries it across the rising edge.
   always_latch begin
      if (!clk) wr_q = ~bus.cpu_we_n;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= c_st_load;
         cnt_q       <= 7'd0;
         cpu_rst_n_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cpu_rst_n_q <= cpu_rst_n_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (bus.ld_start) begin
         state_d = c_st_load;
         cnt_d   = 7'd0;
      end else begin
         case (state_q)
            c_st_load: begin
               if (hs_w) begin
                  cnt_d = cnt_q + 7'd1;
                  if (cnt_q == c_last) state_d = c_st_release;
               end
            end
            c_st_release: state_d = c_st_run;
            c_st_run:     state_d = c_st_run;
            default:      state_d = c_st_load;
         endcase
      end
      cpu_rst_n_d = (state_d == c_st_run);
   end

   // Outputs and RAM write port; loader owns the port in LOAD, the CPU in RUN.
   always_comb begin
      ld_ready_w  = rst & (state_q == c_st_load);
      hs_w        = bus.ld_valid & ld_ready_w;
      mem_we_w    = 1'b0;
      mem_waddr_w = bus.cpu_addr;
      mem_wdata_w = bus.cpu_wdata;
      if (hs_w && !bus.ld_start) begin
         mem_we_w    = 1'b1;
         mem_waddr_w = cnt_q[5:0];
         mem_wdata_w = bus.ld_data;
      end else if (rst && state_q == c_st_run && wr_q) begin
         mem_we_w = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we_w) mem[mem_waddr_w] <= mem_wdata_w;
   end

   assign bus.cpu_rdata = mem[bus.cpu_addr];
   assign bus.cpu_rst_n = cpu_rst_n_q;
   assign bus.ld_ready  = ld_ready_w;
   assign bus.ld_done   = (state_q == c_st_run);

`ifdef MCPU_MEM_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (bus.ld_start)  sum_d = 8'h00;
      else if (hs_w)     sum_d = sum_q + bus.ld_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) sum_q <= 8'h00;
      else      sum_q <= sum_d;
   end

   assign bus.ld_sum = sum_q;
`else
   assign bus.ld_sum = 8'h00;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mcpu_mem.sv
`default_nettype none
// ============================================================================
// tb_mcpu_mem : randomized self-checking bench for mcpu_mem against a
//               behavioural model of the boot loader and RAM.
// Revision    : 1.0
// ============================================================================
module tb_mcpu_mem;
   localparam int LEN = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mcpu_mem_if bus();

   mcpu_mem #(.LOAD_LEN(LEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model: bytes accepted so far in this load, whether the CPU is running.
   logic [7:0] m_mem [64];
   bit         m_vld [64];
   int         m_acc = 0;
   bit         m_run = 1'b0;
   int         m_sum = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int exp_sum();
`ifdef MCPU_MEM_CHECKSUM_EN
      return m_sum;
`else
      return 0;
`endif
   endfunction

   task automatic cycle(input bit r, input bit st, input bit v, input logic [7:0] d,
                        input logic [5:0] a, input logic [7:0] wd, input bit we_in);
      bit we;
      we = we_in && r && !st;
      @(negedge clk);
      rst          = r;
      bus.ld_start = st;
      bus.ld_valid = v;
      bus.ld_data  = d;
      bus.cpu_addr = a;
      bus.cpu_wdata = wd;
      bus.cpu_we_n = ~we;
      #1;
      chk("ld_ready", int'(bus.ld_ready), (r && m_acc < LEN) ? 1 : 0);
      @(posedge clk);
      if (!r) begin
         m_acc = 0; m_sum = 0; m_run = 1'b0;
      end else begin
         if (m_run && we) begin
            m_mem[a] = wd; m_vld[a] = 1'b1;
         end
         if (st) begin
            m_acc = 0; m_sum = 0; m_run = 1'b0;
         end else if (m_acc < LEN) begin
            if (v) begin
               m_mem[m_acc] = d; m_vld[m_acc] = 1'b1;
               m_acc++;
               m_sum = (m_sum + int'(d)) % 256;
            end
         end else begin
            m_run = 1'b1;
         end
      end
      #1;
      bus.cpu_we_n = 1'b1;
      chk("cpu_rst_n", int'(bus.cpu_rst_n), int'(m_run));
      chk("ld_done",   int'(bus.ld_done),   int'(m_run));
      chk("ld_sum",    int'(bus.ld_sum),    exp_sum());
      if (m_vld[a]) chk("cpu_rdata", int'(bus.cpu_rdata), int'(m_mem[a]));
   endtask

   task automatic rnd_cycle(input bit v, input bit we);
      cycle(1'b1, 1'b0, v, 8'($urandom), 6'($urandom), 8'($urandom), we);
   endtask

   task automatic load_until(input int target);
      int guard = 0;
      while (m_acc < target && guard < 1000) begin
         rnd_cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
         guard++;
      end
      if (m_acc < target) chk("load_timeout", m_acc, target);
   endtask

   initial begin
      bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = 8'h00;
      bus.cpu_addr = 6'h00; bus.cpu_wdata = 8'h00; bus.cpu_we_n = 1'b1; bus.cpu_oe_n = 1'b1;
      for (int i = 0; i < 64; i++) begin m_vld[i] = 1'b0; m_mem[i] = 8'h00; end

      cycle(1'b0, 1'b0, 1'b0, 8'h00, 6'h00, 8'h00, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 8'h00, 6'h00, 8'h00, 1'b0);

      // Full boot load 0x00..0x3F; a CPU write to 0x30 mid-load must be ignored.
      for (int i = 0; i < LEN; i++) begin
         if (i == 50) cycle(1'b1, 1'b0, 1'b1, 8'(i), 6'h30, 8'hFF, 1'b1);
         else         cycle(1'b1, 1'b0, 1'b1, 8'(i), 6'($urandom), 8'($urandom), $urandom_range(0, 1) == 1);
      end
      cycle(1'b1, 1'b0, 1'b1, 8'h00, 6'h30, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 6'h05, 8'h00, 1'b0);
      chk("boot_done", int'(bus.ld_done), 1);
      chk("boot_mem5", int'(bus.cpu_rdata), 8'h05);
`ifdef MCPU_MEM_CHECKSUM_EN
      chk("boot_sum", int'(bus.ld_sum), 8'hE0);
`else
      chk("boot_sum", int'(bus.ld_sum), 8'h00);
`endif

      // CPU write in RUN
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 6'h3E, 8'hA5, 1'b1);
      chk("run_wr3e", int'(bus.cpu_rdata), 8'hA5);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 6'h3D, 8'h00, 1'b0);
      chk("run_keep3d", int'(bus.cpu_rdata), 8'h3D);
      for (int i = 0; i < 40; i++) rnd_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);

      // Restart load from RUN, then source gaps 1,0,0,1
      cycle(1'b1, 1'b1, 1'b1, 8'h12, 6'h00, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 8'h5A, 6'h00, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 8'h11, 6'h01, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 8'h22, 6'h01, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 8'hC3, 6'h01, 8'h00, 1'b0);
      chk("gap_mem1", int'(bus.cpu_rdata), 8'hC3);
      chk("gap_cnt", m_acc, 2);

      // ld_start beats a handshake at cnt 10
      load_until(10);
      cycle(1'b1, 1'b1, 1'b1, 8'h77, 6'd10, 8'h00, 1'b0);
      chk("start_not_wr", int'(bus.cpu_rdata == 8'h77 && m_mem[10] != 8'h77), 0);
      cycle(1'b1, 1'b0, 1'b1, 8'h9E, 6'd0, 8'h00, 1'b0);
      chk("start_mem0", int'(bus.cpu_rdata), 8'h9E);

      // Reset mid-load at cnt 20, bytes retained
      load_until(20);
      cycle(1'b0, 1'b0, 1'b1, 8'hEE, 6'd3, 8'h00, 1'b0);
      chk("rst_cnt", m_acc, 0);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 6'(i), 8'h00, 1'b0);

      load_until(LEN);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0)
            cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 6'($urandom), 8'h00, 1'b0);
         else if ($urandom_range(0, 39) == 0)
            cycle(1'b1, 1'b1, 1'b1, 8'($urandom), 6'($urandom), 8'h00, 1'b0);
         else
            rnd_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
